song_sequencer: RTL and testbench

- Sequences `note_player` through a song stored in an external synchronous song ROM.
- Fetches one {note, duration} word per note and presents it with a one-cycle `load_new_note` pulse.
- Waits for `note_done`, then advances to the next note. Stops at an end marker or at the last slot of the song.
- Sits between the top-level play/song-select logic and `note_player`. Drives `note_player`'s `note_to_load`, `duration_to_load` and `load_new_note` inputs.

---
 rtl/song_sequencer_if.sv | 29 ++
 rtl/song_sequencer.sv | 116 +++++++++++
 tb/tb_song_sequencer.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/song_sequencer_if.sv
// Connection bundle between song_sequencer, the play/song-select logic,
// the synchronous song ROM and note_player.
interface song_sequencer_if #(
  parameter int NOTE_BITS = 5,
  parameter int SONG_BITS = 2
);
  logic                           play;
  logic [SONG_BITS-1:0]           song;
  logic                           new_song;
  logic                           note_done;
  logic [SONG_BITS+NOTE_BITS-1:0] rom_addr;
  logic [11:0]                    rom_data;
  logic [5:0]                     note_to_load;
  logic [5:0]                     duration_to_load;
  logic                           load_new_note;
  logic                           song_done;
  logic                           busy;

  // master: the sequencer itself; slave: everything around it
  modport master (
    input  play, song, new_song, note_done, rom_data,
    output rom_addr, note_to_load, duration_to_load, load_new_note, song_done, busy
  );

  modport slave (
    output play, song, new_song, note_done, rom_data,
    input  rom_addr, note_to_load, duration_to_load, load_new_note, song_done, busy
  );
endinterface

// File: rtl/song_sequencer.sv
// Walks note_player through one song of a synchronous song ROM, one
// {note, duration} word per note, stopping at an end marker or the last slot.
module song_sequencer #(
  parameter int NOTE_BITS = 5,
  parameter int SONG_BITS = 2
) (
  input  logic              clk,
  input  logic              reset,
  song_sequencer_if.master  bus
);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    WAIT_ROM,
    LOAD,
    PLAYING
  } state_t;

  localparam logic [NOTE_BITS-1:0] LAST_IDX = '1;

  state_t               state_reg;
  logic [SONG_BITS-1:0] song_reg;
  logic [NOTE_BITS-1:0] note_idx_reg;
  logic [5:0]           note_reg;
  logic [5:0]           duration_reg;
  logic                 load_reg;
  logic                 song_done_reg;
  logic                 pending_reg;
  logic                 stale_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg     <= IDLE;
      song_reg      <= '0;
      note_idx_reg  <= '0;
      note_reg      <= '0;
      duration_reg  <= '0;
      load_reg      <= 1'b0;
      song_done_reg <= 1'b0;
      pending_reg   <= 1'b0;
      stale_reg     <= 1'b0;
    end else begin
      song_done_reg <= 1'b0;
      if (bus.new_song) begin
        song_reg     <= bus.song;
        note_idx_reg <= '0;
        pending_reg  <= 1'b0;
        stale_reg    <= 1'b0;
        load_reg     <= 1'b0;
        state_reg    <= FETCH;
      end else if (state_reg != IDLE && !bus.play) begin
        // Paused: hold everything, remember a finished note and a stale ROM word
        if (bus.note_done)
          pending_reg <= 1'b1;
        if (state_reg == WAIT_ROM)
          stale_reg <= 1'b1;
      end else begin
        case (state_reg)
          IDLE: begin
            state_reg <= IDLE;
          end
          FETCH: begin
            state_reg <= WAIT_ROM;
          end
          WAIT_ROM: begin
            if (stale_reg) begin
              stale_reg <= 1'b0;
              state_reg <= FETCH;
            end else begin
              note_reg     <= bus.rom_data[11:6];
              duration_reg <= bus.rom_data[5:0];
              if (bus.rom_data[5:0] == 6'd0) begin
                song_done_reg <= 1'b1;
                note_idx_reg  <= '0;
                state_reg     <= IDLE;
              end else begin
                load_reg  <= 1'b1;
                state_reg <= LOAD;
              end
            end
          end
          LOAD: begin
            load_reg  <= 1'b0;
            state_reg <= PLAYING;
          end
          PLAYING: begin
            if (bus.note_done || pending_reg) begin
              pending_reg <= 1'b0;
              if (note_idx_reg == LAST_IDX) begin
                song_done_reg <= 1'b1;
                note_idx_reg  <= '0;
                state_reg     <= IDLE;
              end else begin
                note_idx_reg <= note_idx_reg + 1'b1;
                state_reg    <= FETCH;
              end
            end
          end
          default: begin
            state_reg <= IDLE;
          end
        endcase
      end
    end
  end

  assign bus.rom_addr         = {song_reg, note_idx_reg};
  assign bus.note_to_load     = note_reg;
  assign bus.duration_to_load = duration_reg;
  // The load pulse stays armed through a pause in LOAD and shows once play returns
  assign bus.load_new_note    = load_reg & bus.play;
  assign bus.song_done        = song_done_reg;
  assign bus.busy             = (state_reg != IDLE);

endmodule

// File: tb/tb_song_sequencer.sv
// Directed bench for song_sequencer with a synchronous song ROM model.
module tb_song_sequencer;

  logic clk;
  logic reset;
  int   checks;
  int   errors;
  int   loads_seen;

  logic [11:0] rom_mem [128];

  song_sequencer_if #(.NOTE_BITS(5), .SONG_BITS(2)) bus ();

  song_sequencer #(.NOTE_BITS(5), .SONG_BITS(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous ROM: data valid one clock after the address
  always @(posedge clk) bus.rom_data <= rom_mem[bus.rom_addr];

  function automatic logic [11:0] word(input int note, input int dur);
    logic [5:0] n;
    logic [5:0] d;
    n = note[5:0];
    d = dur[5:0];
    return {n, d};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end else begin
      $display("check %s = %0d", tag, got);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic new_song_pulse(input int s);
    bus.song     = s[1:0];
    bus.new_song = 1'b1;
    cyc();
    bus.new_song = 1'b0;
  endtask

  task automatic note_pulse();
    bus.note_done = 1'b1;
    cyc();
    bus.note_done = 1'b0;
  endtask

  // Called in the FETCH cycle; ends in the first PLAYING cycle
  task automatic expect_load(input string tag, input int note, input int dur);
    check({tag, "_fetch_load"}, bus.load_new_note, 0);
    cyc();
    check({tag, "_wait_load"}, bus.load_new_note, 0);
    cyc();
    if (bus.load_new_note === 1'b1) loads_seen++;
    check({tag, "_load"}, bus.load_new_note, 1);
    check({tag, "_note"}, bus.note_to_load, note);
    check({tag, "_dur"}, bus.duration_to_load, dur);
    check({tag, "_no_done"}, bus.song_done, 0);
    cyc();
    check({tag, "_load_clr"}, bus.load_new_note, 0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    loads_seen = 0;
    for (int i = 0; i < 128; i++) rom_mem[i] = word(1, 1);
    for (int i = 0; i < 32; i++) rom_mem[i] = word(i + 1, 5);
    rom_mem[32] = word(10, 4);
    rom_mem[33] = word(12, 2);
    rom_mem[34] = word(7, 0);
    rom_mem[64] = word(20, 3);
    rom_mem[65] = word(0, 3);
    rom_mem[66] = word(21, 2);
    rom_mem[67] = word(9, 0);
    for (int i = 0; i < 32; i++) rom_mem[96 + i] = word(i + 1, 1);

    bus.play      = 1'b0;
    bus.song      = 2'd0;
    bus.new_song  = 1'b0;
    bus.note_done = 1'b0;
    reset         = 1'b0;
    cyc();
    cyc();
    check("rst_busy", bus.busy, 0);
    check("rst_addr", bus.rom_addr, 0);
    check("rst_load", bus.load_new_note, 0);
    check("rst_done", bus.song_done, 0);
    reset = 1'b1;

    // play alone stays idle
    bus.play = 1'b1;
    cyc();
    cyc();
    check("idle_play_busy", bus.busy, 0);

    // Basic play, song 1
    new_song_pulse(1);
    check("basic_addr0", bus.rom_addr, 32);
    check("basic_busy", bus.busy, 1);
    expect_load("basic_n0", 10, 4);
    note_pulse();
    check("basic_addr1", bus.rom_addr, 33);
    expect_load("basic_n1", 12, 2);
    note_pulse();
    check("basic_addr2", bus.rom_addr, 34);
    cyc();
    check("basic_wait_done", bus.song_done, 0);
    cyc();
    check("basic_done", bus.song_done, 1);
    check("basic_done_load", bus.load_new_note, 0);
    check("basic_end_busy", bus.busy, 0);
    cyc();
    check("basic_done_clr", bus.song_done, 0);

    // Full song 3: 32 notes then song_done at the last slot
    loads_seen = 0;
    new_song_pulse(3);
    for (int i = 0; i < 32; i++) begin
      check($sformatf("full_addr%0d", i), bus.rom_addr, 96 + i);
      expect_load($sformatf("full_n%0d", i), i + 1, 1);
      note_pulse();
    end
    check("full_done", bus.song_done, 1);
    check("full_busy", bus.busy, 0);
    check("full_addr_end", bus.rom_addr, 96);
    check("full_loads", loads_seen, 32);
    cyc();
    check("full_done_clr", bus.song_done, 0);

    // Pause in PLAYING with note_done while paused
    new_song_pulse(0);
    check("pause_addr0", bus.rom_addr, 0);
    expect_load("pause_n0", 1, 5);
    bus.play = 1'b0;
    cyc();
    note_pulse();
    cyc();
    check("pause_hold_load", bus.load_new_note, 0);
    check("pause_hold_addr", bus.rom_addr, 0);
    check("pause_hold_busy", bus.busy, 1);
    bus.play = 1'b1;
    cyc();
    check("resume_addr1", bus.rom_addr, 1);
    expect_load("resume_n1", 2, 5);

    // Pause in WAIT_ROM: read is re-issued on resume
    note_pulse();
    check("wr_addr2", bus.rom_addr, 2);
    cyc();
    bus.play = 1'b0;
    cyc();
    cyc();
    check("wr_pause_load", bus.load_new_note, 0);
    bus.play = 1'b1;
    cyc();
    check("wr_refetch_load", bus.load_new_note, 0);
    check("wr_refetch_addr", bus.rom_addr, 2);
    cyc();
    check("wr_wait_load", bus.load_new_note, 0);
    cyc();
    check("wr_load", bus.load_new_note, 1);
    check("wr_note", bus.note_to_load, 3);
    check("wr_dur", bus.duration_to_load, 5);
    cyc();

    // Advance to note 5, then preempt with new_song + note_done together
    for (int i = 3; i <= 5; i++) begin
      note_pulse();
      check($sformatf("pre_addr%0d", i), bus.rom_addr, i);
      expect_load($sformatf("pre_n%0d", i), i + 1, 5);
    end
    bus.song      = 2'd2;
    bus.new_song  = 1'b1;
    bus.note_done = 1'b1;
    cyc();
    bus.new_song  = 1'b0;
    bus.note_done = 1'b0;
    check("preempt_addr", bus.rom_addr, 64);
    check("preempt_no_done", bus.song_done, 0);
    expect_load("preempt_n0", 20, 3);

    // Rest note keeps sequencing
    note_pulse();
    check("rest_addr", bus.rom_addr, 65);
    expect_load("rest_n1", 0, 3);
    note_pulse();
    check("after_rest_addr", bus.rom_addr, 66);
    expect_load("after_rest_n2", 21, 2);
    note_pulse();
    cyc();
    cyc();
    check("s2_done", bus.song_done, 1);

    // Asynchronous reset mid-song
    new_song_pulse(1);
    cyc();
    cyc();
    cyc();
    check("mid_busy", bus.busy, 1);
    #2;
    reset = 1'b0;
    #1;
    check("arst_busy", bus.busy, 0);
    check("arst_addr", bus.rom_addr, 0);
    check("arst_note", bus.note_to_load, 0);
    check("arst_dur", bus.duration_to_load, 0);
    check("arst_load", bus.load_new_note, 0);
    check("arst_done", bus.song_done, 0);
    cyc();
    reset = 1'b1;
    cyc();
    check("arst_stays_idle", bus.busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
